rat_io_responder: RTL and testbench
===================================

RAT_IO_RESPONDER -- requirements
Module: rat_io_responder

Interface
REQ-001 Parameter DB_MAX, default 16'd50000, debounce hold length in CLK cycles (legal range 2..65535).
REQ-002 CLK  input  1  system clock; every register SHALL update on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 PORT_ID  input  8  port address driven by the MCU.
REQ-005 OUT_PORT  input  8  write data driven by the MCU.
REQ-006 IO_STRB  input  1  one-cycle write strobe from the MCU.
REQ-007 IN_PORT  output  8  read data returned to the MCU.
REQ-008 INT  output  1  interrupt request to the MCU; level output, held until acknowledged.
REQ-009 SWITCHES  input  8  asynchronous board switches.
REQ-010 BTN_INT  input  1  asynchronous, bouncing interrupt button.
REQ-011 LEDS  output  8  registered LED outputs.
REQ-012 SSEG_VAL  output  8  registered seven-segment value.

Function
REQ-013 Port map SHALL be: 0x20 read SWITCHES; 0x21 read STATUS (bit0 = pending, bits7:1 = 0); 0x40 write LEDS; 0x81 write SSEG_VAL; 0xF0 write INT_ACK (data ignored).
REQ-014 A write SHALL occur on a rising CLK edge with IO_STRB=1 and a matching PORT_ID; the new value SHALL be visible on the following cycle.
REQ-015 Writes to unmapped or read-only IDs SHALL be ignored; IO_STRB=0 SHALL never modify state.
REQ-016 IN_PORT SHALL be a combinational decode of PORT_ID over registered sources; unmapped IDs SHALL return 0x00.
REQ-017 SWITCHES and BTN_INT SHALL each pass through a two-flop synchronizer; the SWITCHES read value SHALL be the second-stage register.
REQ-018 The debounce FSM SHALL use states IDLE, WAIT_HIGH, HELD, WAIT_LOW and an internal 16-bit counter.
REQ-019 IDLE: synced button = 1 -> WAIT_HIGH, counter cleared.
REQ-020 WAIT_HIGH: synced = 0 -> IDLE; counter = DB_MAX-1 -> HELD with a one-cycle press pulse; otherwise counter increments.
REQ-021 HELD: synced = 0 -> WAIT_LOW, counter cleared.
REQ-022 WAIT_LOW: synced = 1 -> HELD; counter = DB_MAX-1 -> IDLE; otherwise counter increments.
REQ-023 The press pulse SHALL set the pending bit; INT SHALL equal the pending bit.
REQ-024 INT SHALL first be high on the cycle after rising edge DB_MAX+3, counting from the edge that first samples BTN_INT high, provided BTN_INT stays high throughout.
REQ-025 A write to INT_ACK SHALL clear pending; if a press pulse and an INT_ACK write coincide, pending SHALL remain set.
REQ-026 A bounce shorter than DB_MAX cycles SHALL produce no press pulse.
REQ-027 The counter SHALL never wrap, because state exits occur at DB_MAX-1.

Reset
REQ-028 RESET SHALL clear LEDS, SSEG_VAL, pending, the synchronizers and the counter, and SHALL force the FSM to IDLE; INT=0 on the cycle after reset.
REQ-029 RESET during WAIT_HIGH SHALL abort the press, with no INT.
REQ-030 A button still held after reset deasserts SHALL be treated as a new press.
REQ-031 RESET SHALL take priority over simultaneous writes.

Configuration
REQ-032 Macro RAT_IO_INT_EN defined: the synchronizer, debounce logic, pending bit and INT_ACK port SHALL be present as specified above.
REQ-033 Macro RAT_IO_INT_EN undefined: INT SHALL be tied to 0, STATUS SHALL read 0x00, and 0xF0 writes SHALL be ignored; debounce logic SHALL be absent.

Structure
REQ-034 Package rat_io_pkg SHALL hold the port-ID localparams (PORT_SWITCHES, PORT_STATUS, PORT_LEDS, PORT_SSEG, PORT_INT_ACK) and the debounce state enum typedef.
REQ-035 Sub-module rat_io_debounce SHALL contain the BTN_INT synchronizer, FSM and counter, and SHALL output the press pulse.

Verification (DB_MAX=4 unless stated)
REQ-036 Write LEDS: PORT_ID=0x40, OUT_PORT=0xA5, IO_STRB=1 for one cycle -> LEDS=0xA5 next cycle; same write with IO_STRB=0 -> LEDS unchanged.
REQ-037 Read SWITCHES: SWITCHES=0x3C, PORT_ID=0x20 -> IN_PORT=0x3C by the third cycle; PORT_ID=0x55 -> IN_PORT=0x00.
REQ-038 Clean press: BTN_INT held high -> INT rises on the cycle after edge 7; STATUS reads 0x01; INT_ACK write -> INT=0 next cycle.
REQ-039 Bounce: BTN_INT high for 2 cycles, low for 5, repeated 3 times -> INT stays 0.
REQ-040 Collision: press pulse and INT_ACK write in the same cycle -> INT stays 1.
REQ-041 Reset: RESET asserted in WAIT_HIGH with LEDS=0xFF -> LEDS=0x00, INT=0; BTN_INT still high after reset -> INT rises DB_MAX+3 edges later.

Source files
------------

// File: rtl/rat_io_pkg.sv
// Shared definitions for the RAT I/O responder: port map and debounce state encoding.
// Optional interrupt path is selected with the RAT_IO_INT_EN macro in the top module.
package rat_io_pkg;

    // MCU port addresses
    localparam logic [7:0] PORT_SWITCHES = 8'h20;  // read: synchronized switches
    localparam logic [7:0] PORT_STATUS   = 8'h21;  // read: bit0 = interrupt pending
    localparam logic [7:0] PORT_LEDS     = 8'h40;  // write: LED register
    localparam logic [7:0] PORT_SSEG     = 8'h81;  // write: seven-segment value
    localparam logic [7:0] PORT_INT_ACK  = 8'hF0;  // write: clear pending (data ignored)

    // Button debounce states
    typedef enum logic [1:0] {
        StIdle,
        StWaitHigh,
        StHeld,
        StWaitLow
    } db_state_e;

    // True when the MCU strobes a write to the given port this cycle
    function automatic logic is_write(input logic strb, input logic [7:0] id,
                                      input logic [7:0] port);
        return strb && (id == port);
    endfunction

endpackage

// File: rtl/rat_io_responder_if.sv
// MCU I/O bus: port address, write data/strobe, read data and interrupt request.
// Signal names follow the MCU pin names.
interface rat_io_responder_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;
    logic       INT;

    // MCU side
    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  IN_PORT,
        input  INT
    );

    // Peripheral side
    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output IN_PORT,
        output INT
    );
endinterface

// File: rtl/rat_io_debounce.sv
// Button debouncer: two-flop synchronizer followed by a hold-time FSM.
// press_o is a one-cycle pulse on the edge that commits a stable press; it is
// decoded from the FSM state so the pending bit can be set on that same edge.
module rat_io_debounce
    import rat_io_pkg::*;
#(
    parameter logic [15:0] DB_MAX = 16'd50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic        btn_meta_q;
    logic        btn_sync_q;
    db_state_e   state_q;
    logic [15:0] cnt_q;
    logic        cnt_done;

    // Counter reaches its terminal value; every state leaves before it could wrap
    assign cnt_done = (cnt_q == (DB_MAX - 16'd1));

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
        end else begin
            btn_meta_q <= btn_i;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce FSM and hold counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (btn_sync_q) begin
                        state_q <= StWaitHigh;
                        cnt_q   <= 16'd0;
                    end
                end
                StWaitHigh: begin
                    if (!btn_sync_q) begin
                        state_q <= StIdle;
                    end else if (cnt_done) begin
                        state_q <= StHeld;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StHeld: begin
                    if (!btn_sync_q) begin
                        state_q <= StWaitLow;
                        cnt_q   <= 16'd0;
                    end
                end
                StWaitLow: begin
                    // A high glitch during release returns to HELD without a new press
                    if (btn_sync_q) begin
                        state_q <= StHeld;
                    end else if (cnt_done) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

    // Press commits on the same edge that moves WAIT_HIGH -> HELD
    assign press_o = (state_q == StWaitHigh) && btn_sync_q && cnt_done;

endmodule

// File: rtl/rat_io_responder.sv
// RAT MCU I/O responder: switch input port, LED and seven-segment output registers,
// and an optional debounced button interrupt.
// Build option: define RAT_IO_INT_EN to include the button debouncer, pending bit,
// STATUS bit0 and the INT_ACK port; without it INT is tied low and STATUS reads 0x00.
module rat_io_responder
    import rat_io_pkg::*;
#(
    parameter logic [15:0] DB_MAX = 16'd50000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    rat_io_responder_if.slave    bus,
    input  logic [7:0]           SWITCHES,
    input  logic                 BTN_INT,
    output logic [7:0]           LEDS,
    output logic [7:0]           SSEG_VAL
);

    logic [7:0] sw_meta_q;
    logic [7:0] sw_sync_q;
    logic [7:0] leds_q, leds_d;
    logic [7:0] sseg_q, sseg_d;
    logic       pending;

    // Two-flop synchronizer for the board switches
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sw_meta_q <= 8'h00;
            sw_sync_q <= 8'h00;
        end else begin
            sw_meta_q <= SWITCHES;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Output register write decode
    always_comb begin
        leds_d = leds_q;
        sseg_d = sseg_q;
        if (is_write(bus.IO_STRB, bus.PORT_ID, PORT_LEDS)) begin
            leds_d = bus.OUT_PORT;
        end
        if (is_write(bus.IO_STRB, bus.PORT_ID, PORT_SSEG)) begin
            sseg_d = bus.OUT_PORT;
        end
    end

    // Output registers; reset wins over a simultaneous write
    always_ff @(posedge CLK) begin
        if (RESET) begin
            leds_q <= 8'h00;
            sseg_q <= 8'h00;
        end else begin
            leds_q <= leds_d;
            sseg_q <= sseg_d;
        end
    end

`ifdef RAT_IO_INT_EN
    logic press;
    logic int_ack;
    logic pending_q, pending_d;

    rat_io_debounce #(
        .DB_MAX (DB_MAX)
    ) u_debounce (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .btn_i   (BTN_INT),
        .press_o (press)
    );

    assign int_ack = is_write(bus.IO_STRB, bus.PORT_ID, PORT_INT_ACK);

    // Pending bit: a press wins over a coincident acknowledge
    always_comb begin
        pending_d = pending_q;
        if (press) begin
            pending_d = 1'b1;
        end else if (int_ack) begin
            pending_d = 1'b0;
        end
    end

    // Pending register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    // Interrupt path absent: button and hold length have no effect
    logic        unused_btn;
    logic [15:0] unused_db_max;

    assign unused_btn    = BTN_INT;
    assign unused_db_max = DB_MAX;
    assign pending       = 1'b0;
`endif

    // Read mux over registered sources; unmapped IDs read as zero
    always_comb begin
        bus.IN_PORT = 8'h00;
        case (bus.PORT_ID)
            PORT_SWITCHES: bus.IN_PORT = sw_sync_q;
            PORT_STATUS:   bus.IN_PORT = {7'b0000000, pending};
            default:       bus.IN_PORT = 8'h00;
        endcase
    end

    assign bus.INT  = pending;
    assign LEDS     = leds_q;
    assign SSEG_VAL = sseg_q;

endmodule

// File: tb/tb_rat_io_responder.sv
// Scoreboard bench for rat_io_responder (DB_MAX = 4). The driver advances a
// run-length reference model each edge and queues the expected outputs for the
// cycle; a negedge monitor pops and compares. Expectations follow RAT_IO_INT_EN.
module tb_rat_io_responder;

    localparam logic [15:0] DB  = 16'd4;
    localparam int          DBI = 4;
`ifdef RAT_IO_INT_EN
    localparam bit IntEn = 1'b1;
`else
    localparam bit IntEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       btn;
    logic [7:0] leds;
    logic [7:0] sseg;

    rat_io_responder_if bus ();

    rat_io_responder #(
        .DB_MAX (DB)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .bus      (bus),
        .SWITCHES (sw),
        .BTN_INT  (btn),
        .LEDS     (leds),
        .SSEG_VAL (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        logic [7:0] leds;
        logic [7:0] sseg;
        logic [7:0] in_port;
        logic       intr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   phase   = 0;

    // Reference model state
    bit         m_valid = 1'b0;
    logic [7:0] m_leds, m_sseg, m_sw1, m_sw2;
    logic       m_b1, m_b2, m_pend;
    bit         m_armed;
    int         m_hi_run, m_lo_run;

    logic [7:0] g_sw  = 8'h00;
    logic       g_btn = 1'b0;

    function automatic logic [7:0] exp_in(input logic [7:0] id);
        if (id == 8'h20) return m_sw2;
        if (id == 8'h21) return {7'b0000000, m_pend};
        return 8'h00;
    endfunction

    // One clock edge of the specification-level behaviour, using current inputs
    task automatic model_step();
        logic s;
        logic press;
        if (rst) begin
            m_leds = 8'h00; m_sseg = 8'h00; m_sw1 = 8'h00; m_sw2 = 8'h00;
            m_b1 = 1'b0; m_b2 = 1'b0; m_pend = 1'b0;
            m_armed = 1'b1; m_hi_run = 0; m_lo_run = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            s = m_b2;
            press = 1'b0;
            // Armed: DB_MAX+1 consecutive high samples make a press.
            // Disarmed: DB_MAX+1 consecutive low samples re-arm.
            if (m_armed) begin
                if (s) begin
                    m_hi_run++;
                    if (m_hi_run == DBI + 1) begin
                        press = 1'b1; m_armed = 1'b0; m_lo_run = 0;
                    end
                end else begin
                    m_hi_run = 0;
                end
            end else begin
                if (!s) begin
                    m_lo_run++;
                    if (m_lo_run == DBI + 1) begin
                        m_armed = 1'b1; m_hi_run = 0;
                    end
                end else begin
                    m_lo_run = 0;
                end
            end
            if (IntEn) begin
                if (press) m_pend = 1'b1;
                else if (bus.IO_STRB && bus.PORT_ID == 8'hF0) m_pend = 1'b0;
            end
            if (bus.IO_STRB && bus.PORT_ID == 8'h40) m_leds = bus.OUT_PORT;
            if (bus.IO_STRB && bus.PORT_ID == 8'h81) m_sseg = bus.OUT_PORT;
            m_sw2 = m_sw1; m_sw1 = sw;
            m_b2 = m_b1; m_b1 = btn;
        end
    endtask

    // Apply inputs for one cycle, queue this cycle's expectation, then take the edge
    task automatic step(input logic r, input logic [7:0] id, input logic [7:0] d,
                        input logic s);
        exp_t e;
        rst = r; bus.PORT_ID = id; bus.OUT_PORT = d; bus.IO_STRB = s;
        sw = g_sw; btn = g_btn;
        if (m_valid) begin
            e.phase = phase; e.leds = m_leds; e.sseg = m_sseg;
            e.in_port = exp_in(id); e.intr = m_pend;
            exp_q.push_back(e);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h21, 8'h00, 1'b0);
    endtask

    task automatic check8(input string name, input int ph, input logic [7:0] act,
                          input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s phase %0d t=%0t: got %02h required %02h", name, ph, $time,
                      act, req);
    endtask

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check8("leds", mon_e.phase, leds, mon_e.leds);
            check8("sseg", mon_e.phase, sseg, mon_e.sseg);
            check8("in_port", mon_e.phase, bus.IN_PORT, mon_e.in_port);
            check8("int", mon_e.phase, {7'b0000000, bus.INT}, {7'b0000000, mon_e.intr});
        end
    end

    initial begin
        logic [7:0] id;
        rst = 1'b1; sw = 8'h00; btn = 1'b0;
        bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b0;

        // Reset state
        phase = 0;
        step(1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 8'h21, 8'h00, 1'b0);
        idle(2);

        // Writes, strobe-less write, unmapped and read-only writes, idle ack
        phase = 1;
        step(1'b0, 8'h40, 8'hA5, 1'b1);
        step(1'b0, 8'h40, 8'h5A, 1'b0);
        step(1'b0, 8'h81, 8'hC3, 1'b1);
        step(1'b0, 8'h41, 8'h11, 1'b1);
        step(1'b0, 8'h20, 8'h22, 1'b1);
        step(1'b0, 8'hF0, 8'h00, 1'b1);
        idle(2);

        // Switch read through the synchronizer, unmapped read
        phase = 2;
        g_sw = 8'h3C;
        repeat (4) step(1'b0, 8'h20, 8'h00, 1'b0);
        repeat (2) step(1'b0, 8'h55, 8'h00, 1'b0);

        // Clean press, status read, acknowledge, release
        phase = 3;
        g_btn = 1'b1; idle(12);
        step(1'b0, 8'hF0, 8'h9E, 1'b1);
        idle(2);
        g_btn = 1'b0; idle(8);

        // Bounces shorter than the hold time
        phase = 4;
        repeat (3) begin
            g_btn = 1'b1; idle(2);
            g_btn = 1'b0; idle(5);
        end
        idle(6);

        // Acknowledge lands on the press edge (edge DB_MAX+3)
        phase = 5;
        g_btn = 1'b1; idle(6);
        step(1'b0, 8'hF0, 8'h00, 1'b1);
        idle(4);
        step(1'b0, 8'hF0, 8'h00, 1'b1);
        g_btn = 1'b0; idle(8);

        // Reset in WAIT_HIGH with a coincident write, button still held afterwards
        phase = 6;
        step(1'b0, 8'h40, 8'hFF, 1'b1);
        g_btn = 1'b1; idle(4);
        step(1'b1, 8'h40, 8'h77, 1'b1);
        idle(12);
        step(1'b0, 8'hF0, 8'h00, 1'b1);
        g_btn = 1'b0; idle(8);

        // Randomized traffic
        phase = 7;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) g_btn = ~g_btn;
            if ($urandom_range(0, 7) == 0) g_sw = 8'($urandom);
            case ($urandom_range(0, 5))
                0: id = 8'h20;
                1: id = 8'h21;
                2: id = 8'h40;
                3: id = 8'h81;
                4: id = 8'hF0;
                default: id = 8'($urandom);
            endcase
            step(($urandom_range(0, 49) == 0), id, 8'($urandom),
                 ($urandom_range(0, 2) == 0));
        end
        idle(2);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
